mame_keys_encoder: RTL and testbench

//  Inverse of the keyboard decoder: converts parallel start/coin/player/pause state into a

---
 rtl/mame_keys_pkg.sv | 46 ++++
 rtl/mame_keys_code_rom.sv | 19 +
 rtl/mame_keys_encoder.sv | 153 +++++++++++++++
 tb/tb_mame_keys_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mame_keys_pkg.sv
// Shared definitions for the MAME key encoder: control index map, scancode table,
// ps2_key field positions and the encoder state type.
package mame_keys_pkg;

   localparam int unsigned NUM_KEYS = 39;
   localparam int unsigned IDX_W    = 6;

   localparam logic [IDX_W-1:0] IDX_START0 = 6'd0;
   localparam logic [IDX_W-1:0] IDX_COIN0  = 6'd4;
   localparam logic [IDX_W-1:0] IDX_P1     = 6'd8;
   localparam logic [IDX_W-1:0] IDX_P2     = 6'd16;
   localparam logic [IDX_W-1:0] IDX_P3     = 6'd24;
   localparam logic [IDX_W-1:0] IDX_P4     = 6'd31;
   localparam logic [IDX_W-1:0] IDX_PAUSE  = 6'd38;
   localparam logic [IDX_W-1:0] IDX_LAST   = 6'd38;

   localparam int unsigned TOGGLE_BIT  = 10;
   localparam int unsigned PRESSED_BIT = 9;
   localparam int unsigned EXT_BIT     = 8;

   // Bit 8 of each entry selects the E0-prefixed (extended) scancode set.
   localparam logic [8:0] KEY_CODE [NUM_KEYS] = '{
      9'h016, 9'h01e, 9'h026, 9'h025,
      9'h02e, 9'h036, 9'h03d, 9'h03e,
      9'h174, 9'h16b, 9'h172, 9'h175, 9'h014, 9'h011, 9'h029, 9'h012,
      9'h034, 9'h023, 9'h02b, 9'h02d, 9'h01c, 9'h01b, 9'h015, 9'h01d,
      9'h04b, 9'h03b, 9'h042, 9'h043, 9'h114, 9'h059, 9'h05a,
      9'h074, 9'h06b, 9'h072, 9'h075, 9'h070, 9'h071, 9'h15a,
      9'h04d
   };

   typedef enum logic [1:0] {
      SCAN = 2'd0,
      EMIT = 2'd1,
      GAP  = 2'd2
   } enc_state_e;

   function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
      if (idx == IDX_LAST) begin
         return 6'd0;
      end else begin
         return idx + 6'd1;
      end
   endfunction

endpackage

// File: rtl/mame_keys_code_rom.sv
// Combinational control-index to 9-bit scancode lookup; out-of-range indices yield zero.
module mame_keys_code_rom
   import mame_keys_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [8:0]       code
);

   // Table lookup guarded against the unused index range above the last control
   always_comb begin
      code = 9'h000;
      if (idx < IDX_W'(NUM_KEYS)) begin
         code = KEY_CODE[idx];
      end else begin
         code = 9'h000;
      end
   end

endmodule

// File: rtl/mame_keys_encoder.sv
// Parallel start/coin/player/pause state -> round-robin serial MiSTer ps2_key events.
// Define MAME_KEYS_ENC_AUTOREPEAT_EN to re-emit presses of held controls every REPEAT_CYCLES.
module mame_keys_encoder
   import mame_keys_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 4
`ifdef MAME_KEYS_ENC_AUTOREPEAT_EN
   , parameter int unsigned REPEAT_CYCLES = 2000000
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  start,
   input  logic [3:0]  coin,
   input  logic [7:0]  p1,
   input  logic [7:0]  p2,
   input  logic [7:0]  p3,
   input  logic [7:0]  p4,
   input  logic        pause,
   output logic [10:0] ps2_key,
   output logic        busy
);

   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   enc_state_e           state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [NUM_KEYS-1:0]  sent_q, sent_d;
   logic [NUM_KEYS-1:0]  live_s;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [10:0]          key_q, key_d;
   logic                 busy_q, busy_d;
   logic [8:0]           code_s;
   logic                 rep_due_s;
   logic                 unused_s;

   // Bit 7 of p3/p4 has no key assigned
   assign unused_s = p3[7] ^ p4[7];

   mame_keys_code_rom u_code_rom (
      .idx  (idx_q),
      .code (code_s)
   );

   // Flatten the input ports into the control index order
   always_comb begin
      live_s = '0;
      live_s[IDX_START0 +: 4] = start;
      live_s[IDX_COIN0  +: 4] = coin;
      live_s[IDX_P1     +: 8] = p1;
      live_s[IDX_P2     +: 8] = p2;
      live_s[IDX_P3     +: 7] = p3[6:0];
      live_s[IDX_P4     +: 7] = p4[6:0];
      live_s[IDX_PAUSE]       = pause;
   end

`ifdef MAME_KEYS_ENC_AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);

   logic [REP_W-1:0] rep_timer_q, rep_timer_d;

   // Repeat timer: restarts on every emitted event or pending change, saturates when due
   always_comb begin
      rep_timer_d = rep_timer_q;
      if ((state_q == EMIT) || (live_s != sent_q)) begin
         rep_timer_d = '0;
      end else if (rep_timer_q != REP_W'(REPEAT_CYCLES)) begin
         rep_timer_d = rep_timer_q + REP_W'(1);
      end else begin
         rep_timer_d = rep_timer_q;
      end
   end

   assign rep_due_s = (rep_timer_q == REP_W'(REPEAT_CYCLES)) && (live_s == sent_q);

   // Repeat timer register
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_timer_q <= '0;
      end else begin
         rep_timer_q <= rep_timer_d;
      end
   end
`else
   assign rep_due_s = 1'b0;
`endif

   // Scan pointer walk, event formation and inter-event gap
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sent_d  = sent_q;
      gap_d   = gap_q;
      key_d   = key_q;
      case (state_q)
         SCAN: begin
            if (live_s[idx_q] != sent_q[idx_q]) begin
               state_d = EMIT;
            end else if (rep_due_s && live_s[idx_q]) begin
               state_d = EMIT;
            end else begin
               idx_d = next_index(idx_q);
            end
         end
         EMIT: begin
            // Pressed reflects the live level now, so a reverted pulse still leaves sent == live
            key_d[TOGGLE_BIT]  = ~key_q[TOGGLE_BIT];
            key_d[PRESSED_BIT] = live_s[idx_q];
            key_d[EXT_BIT:0]   = code_s;
            sent_d[idx_q]      = live_s[idx_q];
            idx_d              = next_index(idx_q);
            gap_d              = '0;
            state_d            = GAP;
         end
         GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = SCAN;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = SCAN;
            idx_d   = '0;
            gap_d   = '0;
         end
      endcase
      busy_d = (state_d != SCAN) || (live_s != sent_d);
   end

   // Encoder state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SCAN;
         idx_q   <= '0;
         sent_q  <= '0;
         gap_q   <= '0;
         key_q   <= 11'h000;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sent_q  <= sent_d;
         gap_q   <= gap_d;
         key_q   <= key_d;
         busy_q  <= busy_d;
      end
   end

   assign ps2_key = key_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_mame_keys_encoder.sv
// Self-checking bench for mame_keys_encoder: directed steps plus randomized loop-back
// against a behavioural ps2_key consumer model.
module tb_mame_keys_encoder;

   localparam int GAP = 4;
   localparam int REP = 50;

   logic        clk;
   logic        reset;
   logic [3:0]  start, coin;
   logic [7:0]  p1, p2, p3, p4;
   logic        pause;
   logic [10:0] ps2_key;
   logic        busy;

   mame_keys_encoder #(
      .GAP_CYCLES (GAP)
`ifdef MAME_KEYS_ENC_AUTOREPEAT_EN
      , .REPEAT_CYCLES (REP)
`endif
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .coin    (coin),
      .p1      (p1),
      .p2      (p2),
      .p3      (p3),
      .p4      (p4),
      .pause   (pause),
      .ps2_key (ps2_key),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] key;
      int          cyc;
   } ev_t;

   int          total = 0;
   int          passed = 0;
   int          fails = 0;
   int          cyc = 0;
   int          bad_codes = 0;
   ev_t         evq[$];
   logic [38:0] cons = '0;
   logic        prev_tog = 1'b0;

   logic [8:0] codes [39] = '{
      9'h016, 9'h01e, 9'h026, 9'h025, 9'h02e, 9'h036, 9'h03d, 9'h03e,
      9'h174, 9'h16b, 9'h172, 9'h175, 9'h014, 9'h011, 9'h029, 9'h012,
      9'h034, 9'h023, 9'h02b, 9'h02d, 9'h01c, 9'h01b, 9'h015, 9'h01d,
      9'h04b, 9'h03b, 9'h042, 9'h043, 9'h114, 9'h059, 9'h05a,
      9'h074, 9'h06b, 9'h072, 9'h075, 9'h070, 9'h071, 9'h15a, 9'h04d
   };

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer model: every toggle flip is one event; look up its control and latch pressed
   always @(posedge clk) begin : monitor
      int found;
      #1;
      if (reset) begin
         prev_tog = 1'b0;
      end else if (ps2_key[10] !== prev_tog) begin
         prev_tog = ps2_key[10];
         evq.push_back('{key: ps2_key, cyc: cyc});
         found = -1;
         for (int j = 0; j < 39; j++) begin
            if (codes[j] == ps2_key[8:0]) found = j;
         end
         if (found < 0) bad_codes++;
         else cons[found] = ps2_key[9];
      end
   end

   function automatic logic [38:0] live_vec();
      return {pause, p4[6:0], p3[6:0], p2, p1, coin, start};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ev(input string tag, input int budget, output logic [10:0] key, output int ecyc);
      int n = 0;
      while (evq.size() == 0 && n < budget) begin
         tick(1);
         n++;
      end
      chk({tag, "_seen"}, 64'(evq.size() != 0), 64'd1);
      if (evq.size() != 0) begin
         ev_t e;
         e = evq.pop_front();
         key = e.key;
         ecyc = e.cyc;
      end else begin
         key = 11'h000;
         ecyc = 0;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      tick(2);
      while (busy !== 1'b0 && n < 3000) begin
         tick(1);
         n++;
      end
      chk({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic all_zero();
      start = 4'h0; coin = 4'h0; p1 = 8'h00; p2 = 8'h00; p3 = 8'h00; p4 = 8'h00; pause = 1'b0;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      logic [10:0] k;
      int          ec, c0, prev_ec;
      logic        exp_tog;
      logic [8:0]  exp3 [3];
      logic [31:0] r;

      reset = 1'b1;
      all_zero();
      tick(3);
      reset = 1'b0;
      exp_tog = 1'b0;
      chk("rst_key", 64'(ps2_key), 64'h000);
      chk("rst_busy", 64'(busy), 64'd0);

      // Quiet inputs produce nothing
      tick(100);
      chk("idle_key", 64'(ps2_key), 64'h000);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_events", 64'(evq.size()), 64'd0);

      // Single press/release of p1 right (extended code)
      c0 = cyc;
      p1[0] = 1'b1;
      wait_ev("p1r_press", 100, k, ec);
      exp_tog = ~exp_tog;
      chk("p1r_press", 64'(k), 64'({exp_tog, 1'b1, 9'h174}));
      chk("p1r_lat_min", 64'((ec - c0) >= 2), 64'd1);
      chk("p1r_lat_max", 64'((ec - c0) <= 39 + GAP + 2), 64'd1);
      wait_idle("p1r_press");
      p1[0] = 1'b0;
      wait_ev("p1r_rel", 100, k, ec);
      exp_tog = ~exp_tog;
      chk("p1r_rel", 64'(k), 64'({exp_tog, 1'b0, 9'h174}));
      wait_idle("p1r_rel");
      chk("p1r_no_extra", 64'(evq.size()), 64'd0);

      // Simultaneous changes from a known pointer (0 after reset) come out in index order
      reset = 1'b1;
      tick(2);
      start = 4'b0011;
      coin[0] = 1'b1;
      reset = 1'b0;
      exp_tog = 1'b0;
      exp3[0] = 9'h016; exp3[1] = 9'h01e; exp3[2] = 9'h02e;
      prev_ec = 0;
      for (int i = 0; i < 3; i++) begin
         wait_ev("multi", 100, k, ec);
         exp_tog = ~exp_tog;
         chk("multi_key", 64'(k), 64'({exp_tog, 1'b1, exp3[i]}));
         if (i > 0) chk("multi_gap", 64'((ec - prev_ec) >= GAP + 1), 64'd1);
         prev_ec = ec;
      end
      all_zero();
      wait_idle("multi");
      chk("multi_loop", 64'(cons), 64'(live_vec()));
      evq.delete();

      // Randomized loop-back, including changes that land during gaps
      for (int it = 0; it < 12; it++) begin
         r = $urandom; start = r[3:0]; coin = r[7:4]; p1 = r[15:8]; p2 = r[23:16]; p3 = r[31:24];
         r = $urandom; p4 = r[7:0]; pause = r[8];
         tick($urandom_range(30, 0));
         if (it[0]) begin
            r = $urandom; p2 = r[7:0]; coin = r[11:8]; pause = r[12];
         end
         wait_idle("rand");
         chk("rand_loop", 64'(cons), 64'(live_vec()));
         evq.delete();
      end
      chk("rand_codes", 64'(bad_codes), 64'd0);

      // Reset in the middle of a gap, then the held control is re-sent as a fresh press
      all_zero();
      wait_idle("pre_rst");
      evq.delete();
      exp_tog = ps2_key[10];
      p3 = 8'h10;
      wait_ev("p3a_press", 100, k, ec);
      chk("p3a_press", 64'(k), 64'({~exp_tog, 1'b1, 9'h114}));
      reset = 1'b1;
      tick(3);
      chk("midrst_key", 64'(ps2_key), 64'h000);
      chk("midrst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      wait_ev("p3a_fresh", 100, k, ec);
      chk("p3a_fresh", 64'(k), 64'({1'b1, 1'b1, 9'h114}));

      // A pulse on pause that reverts before index 38 is examined leaves no trace
      p3 = 8'h00;
      wait_idle("pre_pulse");
      evq.delete();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(5);
      pause = 1'b1;
      tick(6);
      pause = 1'b0;
      tick(100);
      chk("pulse_no_event", 64'(evq.size()), 64'd0);
      chk("pulse_busy", 64'(busy), 64'd0);

`ifdef MAME_KEYS_ENC_AUTOREPEAT_EN
      // Held pause re-emitted as repeated presses with alternating toggle
      reset = 1'b1;
      tick(2);
      pause = 1'b1;
      reset = 1'b0;
      evq.delete();
      wait_ev("rep_first", 100, k, prev_ec);
      chk("rep_first", 64'(k), 64'({1'b1, 1'b1, 9'h04d}));
      exp_tog = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_ev("rep", REP + 100, k, ec);
         exp_tog = ~exp_tog;
         chk("rep_key", 64'(k), 64'({exp_tog, 1'b1, 9'h04d}));
         chk("rep_period", 64'(((ec - prev_ec) >= REP) && ((ec - prev_ec) <= REP + 39 + GAP + 4)), 64'd1);
         prev_ec = ec;
      end
      pause = 1'b0;
      wait_idle("rep_end");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
